// File: rtl/hist_uploader.sv
// hist_uploader: streams histogram bin counts from the histogram RAM read port
// to the UART_TX byte interface. Each bin is sent LSB first, then MSB. One
// terminator byte follows the last bin, giving 2*N+1 bytes for N bins.
module hist_uploader #(
    parameter int          ADDR_W   = 10,
    parameter int          DATA_W   = 16,
    parameter logic [7:0]  END_BYTE = 8'hFF
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] num_bins,
    output logic              busy,
    output logic              done,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic              tx_dv,
    output logic [7:0]        tx_byte,
    input  logic              tx_active,
    input  logic              tx_done
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD,
        S_RD_WAIT,
        S_LSB,
        S_LSB_WAIT,
        S_MSB,
        S_MSB_WAIT,
        S_END,
        S_END_WAIT,
        S_DONE
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   addr;       // address of the bin being sent
    logic [ADDR_W-1:0]   remaining;  // bins still to send, including the current one
    logic [DATA_W-1:0]   hold;       // bin count captured from the RAM
    logic                abort_q;    // abort seen during this upload

    // State register; areset returns every output to its idle value at once
    // because all outputs are decoded from this register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Upload parameters, bin holding register and abort latch.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            addr      <= '0;
            remaining <= '0;
            hold      <= '0;
            abort_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Parameters are captured only here, so they stay frozen
                    // for the whole upload.
                    if (start) begin
                        addr      <= base_addr;
                        remaining <= num_bins;
                    end
                end
                S_RD_WAIT: begin
                    hold <= ram_rd_data;
                end
                S_MSB_WAIT: begin
                    if (tx_done) begin
                        addr      <= addr + ADDR_W'(1);   // wraps mod 2^ADDR_W
                        remaining <= remaining - ADDR_W'(1);
                    end
                end
                default: begin
                end
            endcase

            // Abort only matters once an upload is running; a new upload
            // always starts with it clear.
            if (state == S_IDLE) begin
                abort_q <= 1'b0;
            end else if (abort) begin
                abort_q <= 1'b1;
            end
        end
    end

    // Next-state and output decode.
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next  = state;
        busy        = 1'b1;
        done        = 1'b0;
        ram_rd_en   = 1'b0;
        ram_rd_addr = '0;
        tx_dv       = 1'b0;
        tx_byte     = 8'h00;

        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = (num_bins == '0) ? S_END : S_RD;
                end
            end
            S_RD: begin
                ram_rd_en   = 1'b1;
                ram_rd_addr = addr;
                state_next  = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                state_next = S_LSB;
            end
            S_LSB: begin
                tx_byte = hold[7:0];
                // An abort that arrived before this bin's LSB went out skips
                // the bin entirely.
                if (abort_q) begin
                    state_next = S_END;
                end else if (!tx_active) begin
                    tx_dv      = 1'b1;
                    state_next = S_LSB_WAIT;
                end
            end
            S_LSB_WAIT: begin
                if (tx_done) begin
                    state_next = S_MSB;
                end
            end
            S_MSB: begin
                // The MSB always follows its LSB, even after an abort.
                tx_byte = hold[15:8];
                if (!tx_active) begin
                    tx_dv      = 1'b1;
                    state_next = S_MSB_WAIT;
                end
            end
            S_MSB_WAIT: begin
                // An abort arriving on the same cycle as tx_done still stops
                // the next RAM read.
                if (tx_done) begin
                    if (remaining == ADDR_W'(1) || abort_q || abort) begin
                        state_next = S_END;
                    end else begin
                        state_next = S_RD;
                    end
                end
            end
            S_END: begin
                tx_byte = END_BYTE;
                if (!tx_active) begin
                    tx_dv      = 1'b1;
                    state_next = S_END_WAIT;
                end
            end
            S_END_WAIT: begin
                if (tx_done) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_hist_uploader.sv
// tb_hist_uploader: drives hist_uploader with directed and randomized uploads.
// A RAM model and a UART_TX model respond to the DUT. A byte/address
// scoreboard built from the upload rules checks every cycle.
module tb_hist_uploader;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;
    localparam int TIMEOUT = 3000;

    logic              clk = 1'b0;
    logic              areset;
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] num_bins;
    logic              busy;
    logic              done;
    logic              ram_rd_en;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic [DATA_W-1:0] ram_rd_data;
    logic              tx_dv;
    logic [7:0]        tx_byte;
    logic              tx_active;
    logic              tx_done;

    hist_uploader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .END_BYTE(8'hFF)) dut (
        .clk         (clk),
        .areset      (areset),
        .start       (start),
        .abort       (abort),
        .base_addr   (base_addr),
        .num_bins    (num_bins),
        .busy        (busy),
        .done        (done),
        .ram_rd_en   (ram_rd_en),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data),
        .tx_dv       (tx_dv),
        .tx_byte     (tx_byte),
        .tx_active   (tx_active),
        .tx_done     (tx_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference state: RAM contents, expected byte stream and read addresses.
    logic [15:0] ram [1024];
    logic [7:0]  exp_q[$];
    int          exp_addr_q[$];
    logic [7:0]  log_q[$];
    int          rd_log_q[$];
    bit          m_busy = 0;
    bit          m_accept = 0;
    bit          first_dv_pending = 0;
    int          exp_first_lat = 0;
    int          since_start = 0;
    int          bytes_seen = 0;
    int          done_cnt = 0;
    bit          prev_dv = 0;

    // UART and RAM model state.
    bit          u_start = 0;
    bit          u_busy = 0;
    int          u_len = 0;
    int          u_cool = 0;
    bit          cool_en = 0;
    bit          r_pend = 0;
    int          r_addr = 0;

    // Build the whole expected stream of one upload from its parameters.
    task automatic build_expect(input int base, input int num);
        exp_q.delete();
        exp_addr_q.delete();
        for (int i = 0; i < num; i++) begin
            int a;
            a = (base + i) % 1024;
            exp_addr_q.push_back(a);
            exp_q.push_back(ram[a][7:0]);
            exp_q.push_back(ram[a][15:8]);
        end
        exp_q.push_back(8'hFF);
    endtask

    // Monitor: compare DUT outputs against the reference once per cycle.
    always @(negedge clk) begin
        if (areset) begin
            prev_dv = 0;
        end else begin
            since_start++;
            if (tx_dv) begin
                check("dv_while_active", tx_active, 0);
                check("dv_width", prev_dv, 0);
                if (first_dv_pending) begin
                    check("first_dv_latency", since_start, exp_first_lat);
                    first_dv_pending = 0;
                end
                if (exp_q.size() == 0) check("extra_byte", exp_q.size(), 1);
                else check("tx_byte", tx_byte, exp_q.pop_front());
                log_q.push_back(tx_byte);
                bytes_seen++;
                u_start = 1;
            end
            prev_dv = tx_dv;
            if (ram_rd_en) begin
                if (exp_addr_q.size() == 0) check("extra_read", exp_addr_q.size(), 1);
                else check("rd_addr", ram_rd_addr, exp_addr_q.pop_front());
                rd_log_q.push_back(int'(ram_rd_addr));
                r_pend = 1;
                r_addr = int'(ram_rd_addr);
            end
            check("busy", busy, m_busy);
            if (done) begin
                check("done_when_idle", m_busy, 1);
                check("done_bytes_left", exp_q.size(), 0);
                done_cnt++;
                m_busy = 0;
            end
            // Abort: finish the bin whose LSB is out, then only the terminator.
            if (abort && m_busy && exp_q.size() > 1) begin
                logic [7:0] keep;
                keep = exp_q[0];
                exp_q.delete();
                if (bytes_seen % 2 == 1) exp_q.push_back(keep);
                exp_q.push_back(8'hFF);
                exp_addr_q.delete();
            end
            if (m_accept) begin
                m_accept = 0;
                m_busy = 1;
                since_start = 0;
                first_dv_pending = 1;
            end
        end
    end

    // RAM read port (1-cycle latency) and UART_TX model, updated after each edge.
    always @(posedge clk) begin
        #1;
        ram_rd_data = r_pend ? ram[r_addr] : 16'($urandom);
        r_pend = 0;
        tx_done = 1'b0;
        if (u_start) begin
            u_start = 0;
            u_busy = 1;
            u_len = $urandom_range(1, 5);
            tx_active = 1'b1;
        end else if (u_busy) begin
            if (u_len > 1) begin
                u_len--;
            end else begin
                u_busy = 0;
                tx_active = 1'b0;
                tx_done = 1'b1;
                u_cool = cool_en ? $urandom_range(0, 2) : 0;
            end
        end else if (u_cool > 0) begin
            u_cool--;
            tx_active = 1'b1;
        end else begin
            tx_active = 1'b0;
        end
    end

    task automatic do_reset();
        areset = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_tx_dv", tx_dv, 0);
        check("rst_rd_en", ram_rd_en, 0);
        check("rst_tx_byte", tx_byte, 0);
        check("rst_rd_addr", ram_rd_addr, 0);
        exp_q.delete();
        exp_addr_q.delete();
        m_busy = 0;
        m_accept = 0;
        first_dv_pending = 0;
        u_start = 0;
        u_busy = 0;
        u_cool = 0;
        r_pend = 0;
        tx_active = 1'b0;
        tx_done = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        areset = 1'b0;
    endtask

    // One upload: optional abort / restart / reset once a byte count is reached.
    task automatic upload(input int base, input int num, input int abort_at,
                          input int restart_at, input int reset_at, input bit abort_with_start);
        int  d0;
        bit  did_abort;
        bit  did_restart;
        bit  was_reset;
        build_expect(base, num);
        log_q.delete();
        rd_log_q.delete();
        did_abort = 0;
        did_restart = 0;
        was_reset = 0;
        @(posedge clk);
        #2;
        d0 = done_cnt;
        bytes_seen = 0;
        base_addr = ADDR_W'(base);
        num_bins = ADDR_W'(num);
        start = 1'b1;
        abort = abort_with_start;
        m_accept = 1;
        exp_first_lat = (num == 0) ? 1 : 3;
        @(posedge clk);
        #2;
        start = 1'b0;
        abort = 1'b0;
        base_addr = ADDR_W'($urandom);
        num_bins = ADDR_W'($urandom);
        for (int cyc = 0; cyc < TIMEOUT && done_cnt == d0; cyc++) begin
            start = 1'b0;
            abort = 1'b0;
            if (reset_at >= 0 && bytes_seen == reset_at) begin
                check("busy_before_reset", busy, 1);
                do_reset();
                was_reset = 1;
                break;
            end
            if (abort_at >= 0 && bytes_seen == abort_at && !did_abort) begin
                abort = 1'b1;
                did_abort = 1;
            end
            if (restart_at >= 0 && bytes_seen == restart_at && !did_restart) begin
                start = 1'b1;
                base_addr = ADDR_W'(500);
                num_bins = ADDR_W'(3);
                did_restart = 1;
            end
            @(posedge clk);
            #2;
        end
        start = 1'b0;
        abort = 1'b0;
        if (!was_reset) begin
            check("done_seen", done_cnt - d0, 1);
            if (done_cnt == d0) begin
                do_reset();
            end else begin
                repeat (4) @(posedge clk);
                #2;
                check("single_done", done_cnt - d0, 1);
                check("bytes_left", exp_q.size(), 0);
                check("reads_left", exp_addr_q.size(), 0);
            end
        end
    endtask

    initial begin
        areset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        base_addr = '0;
        num_bins = '0;
        tx_active = 1'b0;
        tx_done = 1'b0;
        ram_rd_data = '0;
        for (int i = 0; i < 1024; i++) ram[i] = 16'(i * 3 + 256);
        #1;
        check("init_busy", busy, 0);
        check("init_tx_dv", tx_dv, 0);
        check("init_done", done, 0);
        check("init_rd_en", ram_rd_en, 0);
        repeat (3) @(posedge clk);
        #2;
        areset = 1'b0;

        // Full upload from base 10.
        upload(10, 35, -1, -1, -1, 0);
        check("t1_len", log_q.size(), 71);
        check("t1_b0", log_q[0], 8'h1E);
        check("t1_b1", log_q[1], 8'h01);
        check("t1_b68", log_q[68], 8'h84);
        check("t1_b69", log_q[69], 8'h01);
        check("t1_b70", log_q[70], 8'hFF);
        check("t1_reads", rd_log_q.size(), 35);

        // Zero bins: only the terminator, no RAM reads.
        upload(77, 0, -1, -1, -1, 0);
        check("t2_len", log_q.size(), 1);
        check("t2_b0", log_q[0], 8'hFF);
        check("t2_reads", rd_log_q.size(), 0);

        // Address wrap.
        upload(1022, 4, -1, -1, -1, 0);
        check("t3_len", log_q.size(), 9);
        check("t3_a0", rd_log_q[0], 1022);
        check("t3_a1", rd_log_q[1], 1023);
        check("t3_a2", rd_log_q[2], 0);
        check("t3_a3", rd_log_q[3], 1);

        // Start while busy is ignored.
        upload(10, 35, -1, 10, -1, 0);
        check("t4_len", log_q.size(), 71);
        check("t4_b20", log_q[20], 8'h3C);

        // Abort during the 3rd bin's LSB transmission.
        upload(10, 35, 5, -1, -1, 0);
        check("t5_len", log_q.size(), 7);
        check("t5_b4", log_q[4], 8'h24);
        check("t5_b5", log_q[5], 8'h01);
        check("t5_b6", log_q[6], 8'hFF);

        // Start and abort together: start wins.
        upload(50, 3, -1, -1, -1, 1);
        check("t5b_len", log_q.size(), 7);

        // Reset mid-upload, then a fresh upload.
        upload(10, 35, -1, -1, 20, 0);
        upload(300, 2, -1, -1, -1, 0);
        check("t6_len", log_q.size(), 5);
        check("t6_a0", rd_log_q[0], 300);

        // Randomized uploads with random RAM, UART timing and aborts.
        cool_en = 1;
        for (int i = 0; i < 1024; i++) ram[i] = 16'($urandom);
        for (int n = 0; n < 12; n++) begin
            int b;
            int k;
            int ab;
            b = $urandom_range(0, 1023);
            k = $urandom_range(0, 20);
            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 2 * k + 1) : -1;
            upload(b, k, ab, -1, -1, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
